// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle between the fetch stage and its surroundings
// (pipeline control, instruction memory and the IF/ID consumer).
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               jump;
  logic [ADDR_W-1:0]  jump_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic [ADDR_W-1:0]  if_id_pc4;
  logic               if_id_valid;
  logic               halted;
  logic               misalign;

  // Fetch-stage side
  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, halted, misalign
  );

  // Environment side (control, memory, decode)
  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc, if_id_pc4, if_id_valid, halted, misalign
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives instruction memory and
// fills the IF/ID register with stall, flush, redirect and halt handling.
module fetch_stage #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int unsigned OPC_W = 6;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] instr, instr_n;
  logic [ADDR_W-1:0]  ipc, ipc_n;
  logic [ADDR_W-1:0]  ipc4, ipc4_n;
  logic               valid, valid_n;
  logic               halted, halted_n;
  logic               misalign, misalign_n;

  logic               redirect_c;
  logic [ADDR_W-1:0]  target_c;
  logic [ADDR_W-1:0]  target_aligned_c;
  logic [ADDR_W-1:0]  pc_inc_c;
  logic               halt_word_c;

  // Branch is the older instruction, so it beats a jump on the same edge
  assign redirect_c       = bus.branch_taken | bus.jump;
  assign target_c         = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign target_aligned_c = {target_c[ADDR_W-1:2], 2'b00};
  assign pc_inc_c         = pc + ADDR_W'(4);
  assign halt_word_c      = (bus.imem_data[INSTR_W-1 -: OPC_W] == HALT_OPCODE);

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      instr    <= '0;
      ipc      <= '0;
      ipc4     <= '0;
      valid    <= 1'b0;
      halted   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      instr    <= instr_n;
      ipc      <= ipc_n;
      ipc4     <= ipc4_n;
      valid    <= valid_n;
      halted   <= halted_n;
      misalign <= misalign_n;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    ipc_n      = ipc;
    ipc4_n     = ipc4;
    valid_n    = valid;
    halted_n   = halted;
    misalign_n = 1'b0;

    unique case (state)
      BOOT: begin
        state_n = RUN;
      end

      RUN: begin
        if (redirect_c) begin
          pc_n       = target_aligned_c;
          valid_n    = 1'b0;
          misalign_n = (target_c[1:0] != 2'b00);
        end else if (bus.flush) begin
          valid_n = 1'b0;
        end else if (!bus.stall) begin
          instr_n = bus.imem_data;
          ipc_n   = pc;
          ipc4_n  = pc_inc_c;
          valid_n = 1'b1;
          // A halt word freezes the PC on its own address
          if (halt_word_c) begin
            state_n = HALT;
          end else begin
            pc_n = pc_inc_c;
          end
        end
      end

      HALT: begin
        if (redirect_c) begin
          pc_n       = target_aligned_c;
          valid_n    = 1'b0;
          misalign_n = (target_c[1:0] != 2'b00);
          halted_n   = 1'b0;
          state_n    = RUN;
        end else begin
          valid_n  = 1'b0;
          halted_n = 1'b1;
        end
      end

      default: begin
        state_n = BOOT;
      end
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.if_id_instr = instr;
  assign bus.if_id_pc    = ipc;
  assign bus.if_id_pc4   = ipc4;
  assign bus.if_id_valid = valid;
  assign bus.halted      = halted;
  assign bus.misalign    = misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, wrap, stall, redirect priority,
// halt/recovery and flush-vs-stall, with hand-computed expectations.
module tb_fetch_stage;

  logic clk;
  logic rst;
  logic [31:0] mem [0:63];

  int checks;
  int errors;

  fetch_stage_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.jump          = 1'b0;
    bus.branch_target = 8'h00;
    bus.jump_target   = 8'h00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1;
    clear_ctl();

    // Reset state
    step();
    step();
    chk("rst_addr",     32'(bus.imem_addr),   32'h00);
    chk("rst_valid",    32'(bus.if_id_valid), 32'h0);
    chk("rst_halted",   32'(bus.halted),      32'h0);
    chk("rst_misalign", 32'(bus.misalign),    32'h0);
    chk("rst_instr",    bus.if_id_instr,      32'h0);

    // BOOT cycle then first capture
    rst = 1'b0;
    step();
    chk("boot_valid", 32'(bus.if_id_valid), 32'h0);
    chk("boot_addr",  32'(bus.imem_addr),   32'h00);
    step();
    chk("cap0_instr", bus.if_id_instr,      32'h1000_0000);
    chk("cap0_pc",    32'(bus.if_id_pc),    32'h00);
    chk("cap0_pc4",   32'(bus.if_id_pc4),   32'h04);
    chk("cap0_valid", 32'(bus.if_id_valid), 32'h1);
    chk("cap0_addr",  32'(bus.imem_addr),   32'h04);

    // Reset asserted mid-run between edges
    repeat (7) step();
    chk("run_addr20", 32'(bus.imem_addr), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    chk("async_addr",   32'(bus.imem_addr),   32'h00);
    chk("async_valid",  32'(bus.if_id_valid), 32'h0);
    chk("async_halted", 32'(bus.halted),      32'h0);
    step();
    rst = 1'b0;
    step();
    chk("boot2_valid", 32'(bus.if_id_valid), 32'h0);
    chk("boot2_addr",  32'(bus.imem_addr),   32'h00);
    step();
    chk("cap1_instr", bus.if_id_instr,    32'h1000_0000);
    chk("cap1_pc",    32'(bus.if_id_pc),  32'h00);
    chk("cap1_pc4",   32'(bus.if_id_pc4), 32'h04);

    // Sequential fetch across the address wrap
    bus.jump = 1'b1; bus.jump_target = 8'hF8;
    step();
    clear_ctl();
    chk("jf8_addr",  32'(bus.imem_addr),   32'hF8);
    chk("jf8_valid", 32'(bus.if_id_valid), 32'h0);
    step();
    chk("wA_instr", bus.if_id_instr,    32'h1000_003E);
    chk("wA_pc",    32'(bus.if_id_pc),  32'hF8);
    chk("wA_pc4",   32'(bus.if_id_pc4), 32'hFC);
    chk("wA_addr",  32'(bus.imem_addr), 32'hFC);
    step();
    chk("wB_instr", bus.if_id_instr,    32'h1000_003F);
    chk("wB_pc",    32'(bus.if_id_pc),  32'hFC);
    chk("wB_pc4",   32'(bus.if_id_pc4), 32'h00);
    chk("wB_addr",  32'(bus.imem_addr), 32'h00);
    step();
    chk("wC_instr", bus.if_id_instr,    32'h1000_0000);
    chk("wC_pc",    32'(bus.if_id_pc),  32'h00);
    chk("wC_pc4",   32'(bus.if_id_pc4), 32'h04);
    chk("wC_addr",  32'(bus.imem_addr), 32'h04);

    // Stall holds PC and IF/ID
    bus.jump = 1'b1; bus.jump_target = 8'h0C;
    step();
    clear_ctl();
    step();
    chk("pre_stall_addr", 32'(bus.imem_addr), 32'h10);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  32'(bus.imem_addr),   32'h10);
      chk("stall_instr", bus.if_id_instr,      32'h1000_0003);
      chk("stall_pc",    32'(bus.if_id_pc),    32'h0C);
      chk("stall_valid", 32'(bus.if_id_valid), 32'h1);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_instr", bus.if_id_instr,    32'h1000_0004);
    chk("unstall_pc",    32'(bus.if_id_pc),  32'h10);
    chk("unstall_addr",  32'(bus.imem_addr), 32'h14);

    // Branch beats jump and stall
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1; bus.branch_target = 8'h40;
    bus.jump = 1'b1;         bus.jump_target   = 8'h80;
    step();
    clear_ctl();
    chk("prio_addr",     32'(bus.imem_addr),   32'h40);
    chk("prio_valid",    32'(bus.if_id_valid), 32'h0);
    chk("prio_misalign", 32'(bus.misalign),    32'h0);
    step();
    chk("p40_instr", bus.if_id_instr, 32'h1000_0010);

    // Misaligned branch target
    bus.branch_taken = 1'b1; bus.branch_target = 8'h42;
    step();
    clear_ctl();
    chk("mis_addr",  32'(bus.imem_addr),   32'h40);
    chk("mis_pulse", 32'(bus.misalign),    32'h1);
    chk("mis_valid", 32'(bus.if_id_valid), 32'h0);
    step();
    chk("mis_drop",  32'(bus.misalign),    32'h0);
    chk("mis_instr", bus.if_id_instr,      32'h1000_0010);
    chk("mis_pc",    32'(bus.if_id_pc),    32'h40);

    // Halt detection, hold and recovery
    mem[3] = 32'hFC00_0000;
    bus.jump = 1'b1; bus.jump_target = 8'h0C;
    step();
    clear_ctl();
    chk("h_jaddr", 32'(bus.imem_addr), 32'h0C);
    step();
    chk("h_instr",  bus.if_id_instr,      32'hFC00_0000);
    chk("h_valid1", 32'(bus.if_id_valid), 32'h1);
    chk("h_pc",     32'(bus.if_id_pc),    32'h0C);
    chk("h_addr1",  32'(bus.imem_addr),   32'h0C);
    step();
    chk("h_halted", 32'(bus.halted),      32'h1);
    chk("h_valid0", 32'(bus.if_id_valid), 32'h0);
    chk("h_addr2",  32'(bus.imem_addr),   32'h0C);
    bus.flush = 1'b1;
    step();
    clear_ctl();
    chk("hf_halted", 32'(bus.halted),      32'h1);
    chk("hf_valid",  32'(bus.if_id_valid), 32'h0);
    chk("hf_addr",   32'(bus.imem_addr),   32'h0C);
    chk("hf_instr",  bus.if_id_instr,      32'hFC00_0000);
    bus.jump = 1'b1; bus.jump_target = 8'h20;
    step();
    clear_ctl();
    chk("hj_halted", 32'(bus.halted),    32'h0);
    chk("hj_addr",   32'(bus.imem_addr), 32'h20);
    step();
    chk("hr_instr", bus.if_id_instr,      32'h1000_0008);
    chk("hr_valid", 32'(bus.if_id_valid), 32'h1);
    chk("hr_addr",  32'(bus.imem_addr),   32'h24);
    mem[3] = 32'h1000_0003;

    // Flush beats stall, PC holds
    bus.jump = 1'b1; bus.jump_target = 8'h2C;
    step();
    clear_ctl();
    step();
    chk("fs_pre_valid", 32'(bus.if_id_valid), 32'h1);
    chk("fs_pre_addr",  32'(bus.imem_addr),   32'h30);
    bus.flush = 1'b1; bus.stall = 1'b1;
    step();
    clear_ctl();
    chk("fs_valid", 32'(bus.if_id_valid), 32'h0);
    chk("fs_addr",  32'(bus.imem_addr),   32'h30);
    step();
    chk("fs_instr", bus.if_id_instr,      32'h1000_000C);
    chk("fs_pc",    32'(bus.if_id_pc),    32'h30);
    chk("fs_valid2", 32'(bus.if_id_valid), 32'h1);
    chk("fs_addr2", 32'(bus.imem_addr),   32'h34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end; sits directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect and halt detection.

Parameters:
ADDR_W, 8, PC / instruction-memory byte-address width
INSTR_W, 32, instruction width (4 bytes, big-endian assembled by memory)
RESET_PC, 0, PC value loaded on reset
HALT_OPCODE, 6'b111111, opcode field [31:26] that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID register
flush  in  1  invalidate IF/ID contents, hold PC
branch_taken  in  1  redirect to branch_target
branch_target  in  ADDR_W  branch destination byte address
jump  in  1  redirect to jump_target
jump_target  in  ADDR_W  jump destination byte address
imem_addr  out  ADDR_W  current PC to instruction memory
imem_data  in  INSTR_W  instruction word for imem_addr, valid same cycle
if_id_instr  out  INSTR_W  captured instruction
if_id_pc  out  ADDR_W  PC of captured instruction
if_id_pc4  out  ADDR_W  if_id_pc + 4, mod 2^ADDR_W
if_id_valid  out  1  IF/ID holds a live instruction
halted  out  1  fetch frozen by halt opcode
misalign  out  1  one-cycle pulse: accepted redirect target not word aligned

Behaviour:
- Reset (async, asserted at any time, including mid-stall or mid-redirect) forces the following immediately:
  - pc=RESET_PC, state=BOOT
  - if_id_instr/pc/pc4=0, if_id_valid=0
  - halted=0, misalign=0
- imem_addr is the pc register directly; there is no combinational path from any input to imem_addr.
- State BOOT: exactly one cycle after reset release.
  - No capture; if_id_valid stays 0; pc holds RESET_PC.
  - Moves to RUN unconditionally.
  - Redirect, stall and flush are ignored in BOOT.
- State RUN, per rising edge, first match wins:
  1. branch_taken=1: pc<=branch_target&~3, if_id_valid<=0. Overrides stall and jump. Branch wins because it is the older instruction.
  2. jump=1: pc<=jump_target&~3, if_id_valid<=0. Overrides stall.
  3. flush=1: if_id_valid<=0, pc holds. Overrides stall.
  4. stall=1: pc and all if_id_* hold.
  5. Otherwise:
     - pc<=pc+4 (wraps 0xFC->0x00).
     - if_id_instr<=imem_data, if_id_pc<=pc, if_id_pc4<=pc+4 (wrapped), if_id_valid<=1.
     - If imem_data[31:26]==HALT_OPCODE, the same edge also does: state<=HALT, pc holds instead of incrementing.
- misalign <=1 for one cycle when a redirect is accepted with target[1:0]!=0; otherwise 0.
- State HALT:
  - halted=1.
  - The halt word stays visible in IF/ID for exactly one cycle with valid=1; if_id_valid is then forced to 0 for as long as the block is halted.
  - pc frozen at the halt instruction's address.
  - A branch_taken or jump (wrong-path halt squashed by a later stage) applies the RUN redirect rules, clears halted on the same edge, and returns to RUN.
  - flush or stall alone: no effect; remains halted.
  - Only reset or a redirect leaves HALT.
- Halt detection is suppressed on any edge where a redirect or flush wins priority.
- All arithmetic is unsigned ADDR_W-bit and wraps silently; no carry/overflow output.

Test Plan:
- Reset during RUN: assert rst at pc=0x20 between edges -> imem_addr=0x00, if_id_valid=0, halted=0 immediately. Release -> one BOOT cycle with no capture, then capture of word at 0x00 with if_id_pc=0x00, if_id_pc4=0x04.
- Sequential fetch with wrap: start pc=0xF8, memory words A,B,C at 0xF8,0xFC,0x00 -> IF/ID sequence (A,0xF8,0xFC), (B,0xFC,0x00), (C,0x00,0x04); imem_addr goes 0xFC,0x00,0x04.
- Stall: stall=1 for 3 cycles at pc=0x10 -> imem_addr stays 0x10 and IF/ID unchanged. Release -> capture the word at 0x10, pc=0x14.
- Redirect priority and alignment:
  - stall=1, branch_taken=1 (target 0x40) and jump=1 (target 0x80) on the same edge -> pc=0x40, if_id_valid=0, misalign=0.
  - Later branch to target 0x42 -> pc=0x40, misalign=1 for exactly one cycle.
- Halt and recovery:
  - imem_data=32'hFC000000 at pc=0x0C -> IF/ID holds it with valid=1 for one cycle, then halted=1, if_id_valid=0, imem_addr stays 0x0C.
  - flush while halted -> no change.
  - jump to 0x20 -> halted=0, pc=0x20, normal fetch resumes.
- Flush vs stall: flush=1 and stall=1 with a valid IF/ID at pc=0x30 -> if_id_valid=0, pc stays 0x30. Next free edge captures the word at 0x30.
